// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// radix-2 divide, one bit per cycle, with a registered one-cycle write request.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic            we,
  output logic [4:0]      wa,
  output logic [XLEN-1:0] wd
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t              state_q;
  logic [2:0]          f3_q;
  logic [4:0]          rd_q;
  logic [4:0]          cnt_q;
  logic [2*XLEN-1:0]   a_q;      // multiplicand (mul) or divisor in low half (div)
  logic [2*XLEN-1:0]   acc_q;    // product (mul) or remainder in low XLEN+1 bits (div)
  logic [XLEN-1:0]     b_q;      // multiplier (mul) or dividend/quotient shifter (div)
  logic                neg_q;    // sign of product / quotient
  logic                rneg_q;   // sign of remainder
  logic                busy_q;
  logic                done_q;
  logic                we_q;
  logic [4:0]          wa_q;
  logic [XLEN-1:0]     wd_q;

  logic                is_div;
  logic                a_sgn;
  logic                b_sgn;
  logic                neg_a;
  logic                neg_b;
  logic [XLEN-1:0]     abs_a;
  logic [XLEN-1:0]     abs_b;
  logic                fast;
  logic [XLEN-1:0]     fast_res;

  logic [2*XLEN-1:0]   acc_step;
  logic [2*XLEN-1:0]   prod_fin;
  logic [XLEN:0]       rem_shift;
  logic [XLEN:0]       diff;
  logic [XLEN:0]       rem_step;
  logic                q_bit;
  logic [XLEN-1:0]     quo_fin;
  logic [XLEN-1:0]     res_d;

  assign busy = busy_q;
  assign done = done_q;
  assign we   = we_q;
  assign wa   = wa_q;
  assign wd   = wd_q;

  // Operand signedness, magnitudes and divide fast-path detection at accept time
  always_comb begin
    is_div = funct3[2];
    if (is_div) begin
      a_sgn = ~funct3[0];
      b_sgn = ~funct3[0];
    end else begin
      a_sgn = (funct3[1:0] != 2'b11);
      b_sgn = ~funct3[1];
    end
    neg_a = a_sgn & srcA[XLEN-1];
    neg_b = b_sgn & srcB[XLEN-1];
    abs_a = neg_a ? -srcA : srcA;
    abs_b = neg_b ? -srcB : srcB;

    fast     = 1'b0;
    fast_res = '0;
    if (is_div) begin
      if (srcB == '0) begin
        fast     = 1'b1;
        fast_res = funct3[1] ? srcA : '1;
      end else if (!funct3[0] && (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1)) begin
        fast     = 1'b1;
        fast_res = funct3[1] ? '0 : srcA;
      end
    end
  end

  // One iteration of shift-add / restoring divide plus final sign correction
  always_comb begin
    acc_step  = b_q[0] ? (acc_q + a_q) : acc_q;
    prod_fin  = neg_q ? -acc_step : acc_step;
    rem_shift = {acc_q[XLEN-1:0], b_q[XLEN-1]};
    diff      = rem_shift - {1'b0, a_q[XLEN-1:0]};
    q_bit     = ~diff[XLEN];
    rem_step  = q_bit ? diff : rem_shift;
    quo_fin   = {b_q[XLEN-2:0], q_bit};
    if (!f3_q[2]) begin
      res_d = (f3_q[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
    end else if (!f3_q[1]) begin
      res_d = neg_q ? -quo_fin : quo_fin;
    end else begin
      res_d = rneg_q ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      f3_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            f3_q   <= funct3;
            rd_q   <= rd;
            cnt_q  <= '0;
            acc_q  <= '0;
            busy_q <= 1'b1;
            neg_q  <= neg_a ^ neg_b;
            rneg_q <= neg_a;
            a_q    <= {{XLEN{1'b0}}, (is_div ? abs_b : abs_a)};
            b_q    <= is_div ? abs_a : abs_b;
            if (fast) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              we_q    <= (rd != 5'd0);
              wa_q    <= rd;
              wd_q    <= fast_res;
            end else begin
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          cnt_q <= cnt_q + 5'd1;
          if (f3_q[2]) begin
            acc_q <= {{(XLEN-1){1'b0}}, rem_step};
            b_q   <= quo_fin;
          end else begin
            acc_q <= acc_step;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
          end
          if (cnt_q == 5'd31) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            we_q    <= (rd_q != 5'd0);
            wa_q    <= rd_q;
            wd_q    <= res_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, fast paths, control
// corner cases and randomized operations against a plain-arithmetic model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;

  int errors = 0;
  int checks = 0;

  // Observations of the most recent run_op
  logic [31:0] r_wd;
  logic [4:0]  r_wa;
  int          r_done_cyc;
  int          r_done_cnt;
  int          r_we_cnt;
  int          r_busy_cnt;
  bit          r_timeout;

  always #5 clk = ~clk;

  mul_div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .srcA   (srcA),
    .srcB   (srcB),
    .rd     (rd),
    .busy   (busy),
    .done   (done),
    .we     (we),
    .wa     (wa),
    .wd     (wd)
  );

  // Reference: RV32M semantics with 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Issue one operation from a negedge and observe until the unit is idle again.
  // Returns at the first idle negedge, so a following call starts back-to-back.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input bit poke);
    r_done_cnt = 0; r_we_cnt = 0; r_busy_cnt = 0; r_done_cyc = -1;
    r_wd = 'x; r_wa = 'x; r_timeout = 1'b1;
    funct3 = f; srcA = a; srcB = b; rd = d; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    srcA = $urandom; srcB = $urandom; rd = 5'($urandom); funct3 = 3'($urandom);
    for (int k = 1; k <= 60; k++) begin
      if (r_done_cnt > 0 && !busy) begin
        start = 1'b0;
        r_timeout = 1'b0;
        break;
      end
      if (busy) r_busy_cnt++;
      if (done) begin
        r_done_cnt++;
        if (r_done_cnt == 1) begin
          r_done_cyc = k; r_wd = wd; r_wa = wa;
        end
      end
      if (we) r_we_cnt++;
      start = poke && (k == 10 || done);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (we !== 1'b0)   begin errors++; $display("FAIL reset_we got=%b exp=0", we); end
    checks++; if (wa !== 5'd0)   begin errors++; $display("FAIL reset_wa got=%h exp=0", wa); end
    checks++; if (wd !== 32'd0)  begin errors++; $display("FAIL reset_wd got=%h exp=0", wd); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul_basic();
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);
    checks++; if (r_timeout)          begin errors++; $display("FAIL mul_timeout got=timeout exp=done"); end
    checks++; if (r_done_cyc !== 33)  begin errors++; $display("FAIL mul_latency got=%0d exp=33", r_done_cyc); end
    checks++; if (r_wd !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_wd got=%h exp=ffffffeb", r_wd); end
    checks++; if (r_wa !== 5'd5)      begin errors++; $display("FAIL mul_wa got=%0d exp=5", r_wa); end
    checks++; if (r_we_cnt !== 1)     begin errors++; $display("FAIL mul_we got=%0d exp=1", r_we_cnt); end
    checks++; if (r_done_cnt !== 1)   begin errors++; $display("FAIL mul_done_cnt got=%0d exp=1", r_done_cnt); end
    checks++; if (r_busy_cnt !== 33)  begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=33", r_busy_cnt); end
    repeat (3) @(negedge clk);
    checks++; if (wd !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_wd_hold got=%h exp=ffffffeb", wd); end
    checks++; if (wa !== 5'd5)          begin errors++; $display("FAIL mul_wa_hold got=%0d exp=5", wa); end
  endtask

  task automatic test_directed();
    logic [2:0]  tf [11] = '{3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] ta [11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tb [11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] te [11] = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                             32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          tl [11] = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    for (int i = 0; i < 11; i++) begin
      run_op(tf[i], ta[i], tb[i], 5'(i + 1), 1'b0);
      checks++; if (r_wd !== te[i]) begin errors++; $display("FAIL directed_wd[%0d] got=%h exp=%h", i, r_wd, te[i]); end
      checks++; if (r_done_cyc !== tl[i]) begin errors++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, r_done_cyc, tl[i]); end
      checks++; if (r_we_cnt !== 1) begin errors++; $display("FAIL directed_we[%0d] got=%0d exp=1", i, r_we_cnt); end
    end
  endtask

  task automatic test_rd_zero();
    run_op(3'd0, 32'd3, 32'd4, 5'd0, 1'b0);
    checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL rd0_done got=%0d exp=1", r_done_cnt); end
    checks++; if (r_we_cnt !== 0)   begin errors++; $display("FAIL rd0_we got=%0d exp=0", r_we_cnt); end
    checks++; if (r_wd !== 32'd12)  begin errors++; $display("FAIL rd0_wd got=%h exp=c", r_wd); end
  endtask

  task automatic test_ignored_start();
    int extra;
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom; b = $urandom | 32'd1;
    run_op(3'd5, a, b, 5'd9, 1'b1);
    checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL ign_done_cnt got=%0d exp=1", r_done_cnt); end
    checks++; if (r_wd !== model(3'd5, a, b)) begin errors++; $display("FAIL ign_wd got=%h exp=%h", r_wd, model(3'd5, a, b)); end
    extra = 0;
    repeat (5) begin if (busy || done) extra++; @(negedge clk); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ign_extra_activity got=%0d exp=0", extra); end
    run_op(3'd4, 32'd9, 32'd0, 5'd3, 1'b1);
    checks++; if (r_done_cyc !== 1) begin errors++; $display("FAIL ign_fast_latency got=%0d exp=1", r_done_cyc); end
    extra = 0;
    repeat (5) begin if (busy || done) extra++; @(negedge clk); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ign_fast_extra got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_midflight();
    int seen;
    funct3 = 3'd5; srcA = 32'd1000; srcB = 32'd7; rd = 5'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
    checks++; if (we !== 1'b0)   begin errors++; $display("FAIL midrst_we got=%b exp=0", we); end
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin if (done || we || busy) seen++; @(negedge clk); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_ghost got=%0d exp=0", seen); end
    run_op(3'd5, 32'd100, 32'd7, 5'd4, 1'b0);
    checks++; if (r_wd !== 32'd14)    begin errors++; $display("FAIL midrst_fresh_wd got=%h exp=e", r_wd); end
    checks++; if (r_done_cyc !== 33)  begin errors++; $display("FAIL midrst_fresh_latency got=%0d exp=33", r_done_cyc); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f [3] = '{3'd1, 3'd7, 3'd6};
    logic [31:0] a [3] = '{32'h8000_0000, 32'd12345, 32'hFFFF_FF00};
    logic [31:0] b [3] = '{32'h8000_0000, 32'd0, 32'd13};
    for (int i = 0; i < 3; i++) begin
      run_op(f[i], a[i], b[i], 5'd17, 1'b0);
      checks++; if (r_wd !== model(f[i], a[i], b[i])) begin errors++; $display("FAIL b2b_wd[%0d] got=%h exp=%h", i, r_wd, model(f[i], a[i], b[i])); end
      checks++; if (r_done_cyc !== (is_fast(f[i], a[i], b[i]) ? 1 : 33)) begin errors++; $display("FAIL b2b_latency[%0d] got=%0d", i, r_done_cyc); end
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
    logic [31:0] exp;
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      d = 5'($urandom_range(0, 31));
      exp = model(f, a, b);
      run_op(f, a, b, d, 1'b0);
      checks++; if (r_timeout || r_wd !== exp) begin errors++; $display("FAIL rand_wd[%0d] f=%0d a=%h b=%h got=%h exp=%h", i, f, a, b, r_wd, exp); end
      checks++; if (r_done_cyc !== (is_fast(f, a, b) ? 1 : 33)) begin errors++; $display("FAIL rand_latency[%0d] got=%0d", i, r_done_cyc); end
      checks++; if (r_we_cnt !== ((d != 5'd0) ? 1 : 0) || r_wa !== d) begin errors++; $display("FAIL rand_write[%0d] we=%0d wa=%0d exp_wa=%0d", i, r_we_cnt, r_wa, d); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; funct3 = '0; srcA = '0; srcB = '0; rd = '0;
    @(negedge clk);
    test_reset();
    test_mul_basic();
    test_directed();
    test_rd_zero();
    test_ignored_start();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
